// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I control FSM: decodes the latched instruction, sequences datapath
// muxes, memory and register-file enables, flags illegal opcodes and counts retirements.
module riscv_mc_controller #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  instr,
    input  logic             mem_ready,
    input  logic             res_zero,
    input  logic             res_lsb,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_req,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       imm_src,
    output logic [3:0]       alu_cntrl,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_BRANCH   = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [1:0] A_PC = 2'b00, A_OLDPC = 2'b01, A_RS1 = 2'b10, A_ZERO = 2'b11;
    localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10;
    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;

    state_t           state_r;
    state_t           state_next_s;
    logic             illegal_r;
    logic [CNT_W-1:0] instret_r;
    logic [6:0]       opcode_s;
    logic [2:0]       funct3_s;
    logic             unused_instr_s;

    assign opcode_s       = instr[6:0];
    assign funct3_s       = instr[14:12];
    assign unused_instr_s = ^{instr[XLEN-1:31], instr[29:15], instr[11:7]};
    assign illegal        = illegal_r;
    assign instret        = instret_r;

    // funct3 to ALU op; sub_en/sra_en carry the instr[30] qualifier where it applies
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub_en, input logic sra_en);
        logic [3:0] op;
        case (f3)
            3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = sra_en ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // State register, sticky illegal flag and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_FETCH;
            illegal_r <= 1'b0;
            instret_r <= '0;
        end else begin
            state_r <= state_next_s;
            if (state_next_s == S_TRAP) begin
                illegal_r <= 1'b1;
            end
            if ((state_r != S_FETCH) && (state_next_s == S_FETCH)) begin
                instret_r <= instret_r + CNT_W'(1);
            end
        end
    end

    // Next-state and Moore strobe decode; reset cycle forces every strobe low
    always_comb begin
        state_next_s = state_r;
        pc_write     = 1'b0;
        adr_src      = 1'b0;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        result_src   = RES_ALUOUT;
        alu_src_a    = A_PC;
        alu_src_b    = B_RS2;
        imm_src      = IMM_I;
        alu_cntrl    = ALU_ADD;
        if (rst) begin
            state_next_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH: begin
                    mem_req      = 1'b1;
                    alu_src_b    = B_FOUR;
                    result_src   = RES_ALU;
                    ir_write     = mem_ready;
                    pc_write     = mem_ready;
                    state_next_s = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_a = A_OLDPC;
                    alu_src_b = B_IMM;
                    imm_src   = (opcode_s == OP_JAL) ? IMM_J : IMM_B;
                    case (opcode_s)
                        OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
                        OP_R:              state_next_s = S_EXECR;
                        OP_I:              state_next_s = S_EXECI;
                        OP_JAL:            state_next_s = S_JAL;
                        OP_JALR:           state_next_s = S_JALR;
                        OP_BR:             state_next_s = S_BRANCH;
                        OP_LUI:            state_next_s = S_LUI;
                        default:           state_next_s = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = A_RS1;
                    alu_src_b = B_IMM;
                    // opcode bit 5 separates stores from loads
                    if (opcode_s[5]) begin
                        imm_src      = IMM_S;
                        state_next_s = S_MEMWRITE;
                    end else begin
                        imm_src      = IMM_I;
                        state_next_s = S_MEMREAD;
                    end
                end
                S_MEMREAD: begin
                    mem_req      = 1'b1;
                    adr_src      = 1'b1;
                    state_next_s = mem_ready ? S_MEMWB : S_MEMREAD;
                end
                S_MEMWB: begin
                    result_src   = RES_MEM;
                    reg_write    = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req      = 1'b1;
                    mem_write    = 1'b1;
                    adr_src      = 1'b1;
                    state_next_s = mem_ready ? S_FETCH : S_MEMWRITE;
                end
                S_EXECR: begin
                    alu_src_a    = A_RS1;
                    alu_src_b    = B_RS2;
                    alu_cntrl    = alu_decode(funct3_s, instr[30], instr[30]);
                    state_next_s = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a    = A_RS1;
                    alu_src_b    = B_IMM;
                    imm_src      = IMM_I;
                    alu_cntrl    = alu_decode(funct3_s, 1'b0, instr[30]);
                    state_next_s = S_ALUWB;
                end
                S_ALUWB: begin
                    result_src   = RES_ALUOUT;
                    reg_write    = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_JAL: begin
                    alu_src_a    = A_OLDPC;
                    alu_src_b    = B_FOUR;
                    result_src   = RES_ALUOUT;
                    pc_write     = 1'b1;
                    state_next_s = S_ALUWB;
                end
                S_JALR: begin
                    // target is parked in alu_out; JAL then loads it and links
                    alu_src_a    = A_RS1;
                    alu_src_b    = B_IMM;
                    imm_src      = IMM_I;
                    result_src   = RES_ALU;
                    state_next_s = S_JAL;
                end
                S_BRANCH: begin
                    alu_src_a    = A_RS1;
                    alu_src_b    = B_RS2;
                    result_src   = RES_ALUOUT;
                    state_next_s = S_FETCH;
                    case (funct3_s)
                        3'b000:  begin alu_cntrl = ALU_XOR;  pc_write = res_zero;  end
                        3'b001:  begin alu_cntrl = ALU_XOR;  pc_write = ~res_zero; end
                        3'b100:  begin alu_cntrl = ALU_SLT;  pc_write = res_lsb;   end
                        3'b101:  begin alu_cntrl = ALU_SLT;  pc_write = ~res_lsb;  end
                        3'b110:  begin alu_cntrl = ALU_SLTU; pc_write = res_lsb;   end
                        3'b111:  begin alu_cntrl = ALU_SLTU; pc_write = ~res_lsb;  end
                        default: state_next_s = S_TRAP;
                    endcase
                end
                S_LUI: begin
                    alu_src_a    = A_ZERO;
                    alu_src_b    = B_IMM;
                    imm_src      = IMM_U;
                    state_next_s = S_ALUWB;
                end
                S_TRAP: begin
                    state_next_s = S_TRAP;
                end
                default: begin
                    state_next_s = S_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Bench for riscv_mc_controller: directed vector table, multi-cycle corner sequences,
// then a random instruction stream checked against a per-instruction step model.
module tb_riscv_mc_controller;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SRAI = 32'h4020D193;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BLTU = 32'h0020E463;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    // strobe order: pc_write, adr_src, mem_req, mem_write, ir_write, reg_write
    typedef struct packed {
        logic [5:0] strb;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] imm;
        logic [3:0] alu;
    } outs_t;

    typedef struct {
        outs_t o;
        logic  wt;
        string nm;
    } step_t;

    typedef struct {
        logic        r;
        logic        rdy;
        logic [31:0] ins;
        logic        rz;
        logic        rl;
        outs_t       o;
        int          cnt;
    } vec_t;

    logic             clk, rst, mem_ready, res_zero, res_lsb;
    logic [XLEN-1:0]  instr;
    logic             pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, illegal;
    logic [1:0]       result_src, alu_src_a, alu_src_b;
    logic [2:0]       imm_src;
    logic [3:0]       alu_cntrl;
    logic [CNT_W-1:0] instret;

    riscv_mc_controller #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .res_zero(res_zero), .res_lsb(res_lsb), .pc_write(pc_write), .adr_src(adr_src),
        .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_cntrl(alu_cntrl), .illegal(illegal), .instret(instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    int               n_vec = 0;
    int               n_err = 0;
    logic [31:0]      cur_ins = 32'h0;
    logic             cur_rz = 1'b0, cur_rl = 1'b0;
    logic             ill_exp = 1'b0;
    logic [CNT_W-1:0] cnt_exp = '0;
    step_t            steps_q[$];
    outs_t            o_zero, o_fetch, o_dec_b, o_aluwb;
    vec_t             tbl[23];

    function automatic outs_t mk(input logic [5:0] s, input logic [1:0] rs, input logic [1:0] a,
                                 input logic [1:0] b, input logic [2:0] imm, input logic [3:0] alu);
        return outs_t'({s, rs, a, b, imm, alu});
    endfunction

    function automatic outs_t not_ready(input outs_t o);
        outs_t r;
        r = o;
        r.strb[5] = 1'b0;
        r.strb[1] = 1'b0;
        return r;
    endfunction

    function automatic bit legal(input logic [6:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_JALR, OP_BR, OP_LUI};
    endfunction

    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt, input bit is_r);
        logic [3:0] base [8];
        logic [3:0] r;
        base = '{4'd0, 4'd4, 4'd6, 4'd5, 4'd7, 4'd8, 4'd3, 4'd2};
        r = base[f3];
        if (f3 == 3'd0 && is_r && alt) r = 4'd1;
        if (f3 == 3'd5 && alt) r = 4'd9;
        return r;
    endfunction

    task automatic cycle(input logic r, input logic rdy, input outs_t eo, input logic eill,
                         input logic [CNT_W-1:0] ecnt, input bit strb_only, input string nm);
        outs_t act;
        @(negedge clk);
        rst = r; mem_ready = rdy; instr = cur_ins; res_zero = cur_rz; res_lsb = cur_rl;
        #1;
        act = mk({pc_write, adr_src, mem_req, mem_write, ir_write, reg_write},
                 result_src, alu_src_a, alu_src_b, imm_src, alu_cntrl);
        n_vec++;
        if (act !== eo || (!strb_only && (illegal !== eill || instret !== ecnt))) begin
            n_err++;
            $display("FAIL %s @%0t: got outs=%h illegal=%b instret=%0d, expected outs=%h illegal=%b instret=%0d",
                     nm, $time, act, illegal, instret, eo, eill, ecnt);
        end
    endtask

    task automatic mcycle(input logic rdy, input outs_t eo, input string nm);
        cycle(1'b0, rdy, eo, ill_exp, cnt_exp, 1'b0, nm);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'($urandom_range(0, 1)), o_zero, 1'b0, '0, 1'b1, "reset");
        cnt_exp = '0;
        ill_exp = 1'b0;
    endtask

    task automatic add_step(input outs_t o, input logic wt, input string nm);
        step_t s;
        s.o = o; s.wt = wt; s.nm = nm;
        steps_q.push_back(s);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, straight from its class
    task automatic build_steps(input logic [31:0] ins, input logic rz, input logic rl);
        logic [6:0] op;
        logic [2:0] f3;
        logic       tk;
        logic [3:0] balu;
        op = ins[6:0];
        f3 = ins[14:12];
        steps_q.delete();
        add_step(o_fetch, 1'b1, "fetch");
        add_step(mk(6'b0, 2'b00, 2'b01, 2'b01, (op == OP_JAL) ? 3'b011 : 3'b010, 4'd0), 1'b0, "decode");
        case (op)
            OP_R: begin
                add_step(mk(6'b0, 2'b00, 2'b10, 2'b00, 3'b000, ref_alu(f3, ins[30], 1'b1)), 1'b0, "execr");
                add_step(o_aluwb, 1'b0, "aluwb");
            end
            OP_I: begin
                add_step(mk(6'b0, 2'b00, 2'b10, 2'b01, 3'b000, ref_alu(f3, ins[30], 1'b0)), 1'b0, "execi");
                add_step(o_aluwb, 1'b0, "aluwb");
            end
            OP_LOAD: begin
                add_step(mk(6'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0), 1'b0, "memadr_ld");
                add_step(mk(6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0), 1'b1, "memread");
                add_step(mk(6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 4'd0), 1'b0, "memwb");
            end
            OP_STORE: begin
                add_step(mk(6'b0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0), 1'b0, "memadr_st");
                add_step(mk(6'b011100, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0), 1'b1, "memwrite");
            end
            OP_JAL: begin
                add_step(mk(6'b100000, 2'b00, 2'b01, 2'b10, 3'b000, 4'd0), 1'b0, "jal");
                add_step(o_aluwb, 1'b0, "aluwb");
            end
            OP_JALR: begin
                add_step(mk(6'b0, 2'b10, 2'b10, 2'b01, 3'b000, 4'd0), 1'b0, "jalr");
                add_step(mk(6'b100000, 2'b00, 2'b01, 2'b10, 3'b000, 4'd0), 1'b0, "jal");
                add_step(o_aluwb, 1'b0, "aluwb");
            end
            OP_BR: begin
                tk   = (f3[2] ? rl : rz) ^ f3[0];
                balu = !f3[2] ? 4'd7 : (!f3[1] ? 4'd6 : 4'd5);
                add_step(mk({tk, 5'b0}, 2'b00, 2'b10, 2'b00, 3'b000, balu), 1'b0, "branch");
            end
            OP_LUI: begin
                add_step(mk(6'b0, 2'b00, 2'b11, 2'b01, 3'b100, 4'd0), 1'b0, "lui");
                add_step(o_aluwb, 1'b0, "aluwb");
            end
            default: begin
            end
        endcase
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic rz, input logic rl,
                             input int fstall, input int mstall);
        int n;
        cur_ins = ins; cur_rz = rz; cur_rl = rl;
        build_steps(ins, rz, rl);
        foreach (steps_q[i]) begin
            if (steps_q[i].wt) begin
                n = (i == 0) ? fstall : mstall;
                if (n < 0) n = int'($urandom_range(0, 3));
                repeat (n) mcycle(1'b0, not_ready(steps_q[i].o), {steps_q[i].nm, "_stall"});
                mcycle(1'b1, steps_q[i].o, steps_q[i].nm);
            end else begin
                mcycle(1'($urandom_range(0, 1)), steps_q[i].o, steps_q[i].nm);
            end
        end
        if (legal(ins[6:0])) cnt_exp = cnt_exp + 1'b1;
    endtask

    initial begin
        logic [31:0] ins;
        logic [2:0]  bf;
        o_zero  = mk(6'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0);
        o_fetch = mk(6'b101010, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0);
        o_dec_b = mk(6'b0, 2'b00, 2'b01, 2'b01, 3'b010, 4'd0);
        o_aluwb = mk(6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0);

        tbl[0]  = '{1'b1, 1'b1, I_ADD,  1'b0, 1'b0, o_zero, 0};
        tbl[1]  = '{1'b0, 1'b1, I_ADD,  1'b0, 1'b0, o_fetch, 0};
        tbl[2]  = '{1'b0, 1'b1, I_ADD,  1'b0, 1'b0, o_dec_b, 0};
        tbl[3]  = '{1'b0, 1'b1, I_ADD,  1'b0, 1'b0, mk(6'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd0), 0};
        tbl[4]  = '{1'b0, 1'b1, I_ADD,  1'b0, 1'b0, o_aluwb, 0};
        tbl[5]  = '{1'b0, 1'b1, I_SUB,  1'b0, 1'b0, o_fetch, 1};
        tbl[6]  = '{1'b0, 1'b1, I_SUB,  1'b0, 1'b0, o_dec_b, 1};
        tbl[7]  = '{1'b0, 1'b1, I_SUB,  1'b0, 1'b0, mk(6'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1), 1};
        tbl[8]  = '{1'b0, 1'b1, I_SUB,  1'b0, 1'b0, o_aluwb, 1};
        tbl[9]  = '{1'b0, 1'b1, I_SRAI, 1'b0, 1'b0, o_fetch, 2};
        tbl[10] = '{1'b0, 1'b1, I_SRAI, 1'b0, 1'b0, o_dec_b, 2};
        tbl[11] = '{1'b0, 1'b1, I_SRAI, 1'b0, 1'b0, mk(6'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd9), 2};
        tbl[12] = '{1'b0, 1'b1, I_SRAI, 1'b0, 1'b0, o_aluwb, 2};
        tbl[13] = '{1'b0, 1'b1, I_BEQ,  1'b1, 1'b0, o_fetch, 3};
        tbl[14] = '{1'b0, 1'b1, I_BEQ,  1'b1, 1'b0, o_dec_b, 3};
        tbl[15] = '{1'b0, 1'b1, I_BEQ,  1'b1, 1'b0, mk(6'b100000, 2'b00, 2'b10, 2'b00, 3'b000, 4'd7), 3};
        tbl[16] = '{1'b0, 1'b1, I_BEQ,  1'b0, 1'b0, o_fetch, 4};
        tbl[17] = '{1'b0, 1'b1, I_BEQ,  1'b0, 1'b0, o_dec_b, 4};
        tbl[18] = '{1'b0, 1'b1, I_BEQ,  1'b0, 1'b0, mk(6'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd7), 4};
        tbl[19] = '{1'b0, 1'b1, I_BLTU, 1'b0, 1'b1, o_fetch, 5};
        tbl[20] = '{1'b0, 1'b1, I_BLTU, 1'b0, 1'b1, o_dec_b, 5};
        tbl[21] = '{1'b0, 1'b1, I_BLTU, 1'b0, 1'b1, mk(6'b100000, 2'b00, 2'b10, 2'b00, 3'b000, 4'd5), 5};
        tbl[22] = '{1'b0, 1'b0, I_LW,   1'b0, 1'b0, not_ready(o_fetch), 6};

        rst = 1'b1; mem_ready = 1'b0; instr = '0; res_zero = 1'b0; res_lsb = 1'b0;
        cycle(1'b1, 1'b1, o_zero, 1'b0, '0, 1'b1, "reset_first");

        for (int i = 0; i < 23; i++) begin
            cur_ins = tbl[i].ins; cur_rz = tbl[i].rz; cur_rl = tbl[i].rl;
            cycle(tbl[i].r, tbl[i].rdy, tbl[i].o, 1'b0, CNT_W'(tbl[i].cnt), 1'b0, $sformatf("vec%0d", i));
        end
        cnt_exp = CNT_W'(6);

        // load with three not-ready cycles in MEMREAD
        run_instr(I_LW, 1'b0, 1'b0, 0, 3);

        // reset while a store is waiting on memory
        cur_ins = I_SW;
        build_steps(I_SW, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) mcycle(1'b1, steps_q[i].o, steps_q[i].nm);
        mcycle(1'b0, steps_q[3].o, "memwrite_wait");
        cycle(1'b1, 1'b0, o_zero, 1'b0, '0, 1'b1, "rst_mid_memwrite");
        cnt_exp = '0;
        mcycle(1'b0, not_ready(o_fetch), "fetch_after_rst");

        // illegal opcode parks in TRAP until reset
        run_instr(I_ILL, 1'b0, 1'b0, 0, 0);
        ill_exp = 1'b1;
        repeat (10) mcycle(1'($urandom_range(0, 1)), o_zero, "trap_hold");
        do_reset();
        mcycle(1'b0, not_ready(o_fetch), "fetch_after_trap_rst");

        for (int k = 0; k < 300; k++) begin
            ins = $urandom;
            if ($urandom_range(0, 24) == 0) begin
                while (legal(ins[6:0])) ins[6:0] = 7'($urandom);
                run_instr(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
                ill_exp = 1'b1;
                repeat ($urandom_range(1, 3)) mcycle(1'($urandom_range(0, 1)), o_zero, "trap_rand");
                do_reset();
            end else begin
                case ($urandom_range(0, 7))
                    0: ins[6:0] = OP_R;
                    1: ins[6:0] = OP_I;
                    2: ins[6:0] = OP_LOAD;
                    3: ins[6:0] = OP_STORE;
                    4: ins[6:0] = OP_JAL;
                    5: ins[6:0] = OP_JALR;
                    6: begin
                        ins[6:0] = OP_BR;
                        bf = 3'($urandom_range(0, 5));
                        ins[14:12] = (bf < 3'd2) ? bf : bf + 3'd2;
                    end
                    default: ins[6:0] = OP_LUI;
                endcase
                run_instr(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_mc_controller.md
Name: riscv_mc_controller

Overview:
- Multi-cycle control FSM for the RV32I core. It decodes the latched instruction and sequences the datapath muxes, memory and register-file enables.
- It is the producing end of the ALU's 4-bit operation code: it drives alu_cntrl every cycle and reads back datapath result status for branch resolution.
- Sits between the instruction register and the datapath. Stalls on a memory ready handshake. Counts retired instructions.

Parameters:
- XLEN, 32, instruction/datapath width.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr  in  XLEN  instruction register contents
- mem_ready  in  1  memory access completes this cycle
- res_zero  in  1  current ALU result == 0
- res_lsb  in  1  current ALU result bit 0
- pc_write  out  1  load PC from result bus
- adr_src  out  1  memory address: 0=PC, 1=alu_out reg
- mem_req  out  1  memory access request
- mem_write  out  1  store strobe (qualified by mem_req)
- ir_write  out  1  latch instr and old_pc
- reg_write  out  1  register-file write enable
- result_src  out  2  00=alu_out reg, 01=mem data, 10=ALU result
- alu_src_a  out  2  00=PC, 01=old_pc, 10=rs1, 11=zero
- alu_src_b  out  2  00=rs2, 01=imm, 10=const 4
- imm_src  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- alu_cntrl  out  4  0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sltu, 6 slt, 7 xor, 8 srl, 9 sra
- illegal  out  1  sticky illegal-opcode flag
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Registered state.
- All strobes are Moore outputs of state, gated by mem_ready where noted.
- Reset (synchronous, any state, including mid-memory-access):
  - state=FETCH, illegal=0, instret=0.
  - During the reset cycle all strobes are 0 and alu_cntrl=0.
- FETCH:
  - Drives mem_req=1, adr_src=0, a=PC, b=4, alu_cntrl=0, result_src=10.
  - ir_write and pc_write are asserted only when mem_ready=1; the FSM moves to DECODE only on that cycle.
  - If mem_ready=0 the FSM holds FETCH indefinitely.
- DECODE:
  - Drives a=old_pc, b=imm, imm_src=B (J for opcode 1101111), add; the target lands in alu_out.
  - Next state by opcode: 0000011/0100011→MEMADR; 0110011→EXECR; 0010011→EXECI; 1101111→JAL; 1100111→JALR; 1100011→BRANCH; 0110111→LUI; otherwise→TRAP.
- MEMADR:
  - Drives a=rs1, b=imm, add; imm_src=I for loads, S for stores.
  - Next state: MEMREAD for loads, MEMWRITE for stores.
- MEMREAD:
  - Drives mem_req=1, adr_src=1.
  - Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE:
  - Drives mem_req=1, mem_write=1, adr_src=1.
  - Holds until mem_ready=1, then goes to FETCH.
- EXECR:
  - Drives a=rs1, b=rs2; then ALUWB.
  - funct3 map: 000→add (funct7[5]=0) or sub (=1); 001→sll; 010→slt(6); 011→sltu(5); 100→xor; 101→srl (instr[30]=0) or sra (=1); 110→or; 111→and.
- EXECI:
  - Drives a=rs1, b=imm, imm_src=I; then ALUWB.
  - Same funct3 map, except 000 is always add; instr[30] selects sra only for funct3=101.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- JAL:
  - Drives a=old_pc, b=4, add; result_src=00 (target); pc_write=1; then ALUWB.
  - ALUWB writes old_pc+4 to rd.
- JALR:
  - Drives a=rs1, b=imm (I), add; result_src=10.
  - Sets pc_write=0 this cycle and captures the target in alu_out; then JAL.
- BRANCH:
  - Drives a=rs1, b=rs2, result_src=00 (target from DECODE); then FETCH.
  - funct3 000/001: alu_cntrl=7; taken = res_zero / ~res_zero.
  - funct3 100/101: alu_cntrl=6; taken = res_lsb / ~res_lsb.
  - funct3 110/111: alu_cntrl=5; taken = res_lsb / ~res_lsb.
  - pc_write = taken. Other funct3 values → TRAP.
- LUI: drives a=zero, b=imm (U), add; then ALUWB.
- TRAP: all strobes 0, illegal=1; remains until rst.
- instret:
  - Increments by 1 on every transition into FETCH from a non-FETCH state.
  - Wraps modulo 2^CNT_W; no saturation.
- Default values: in any state, any strobe not listed is 0; alu_cntrl defaults to 0.
- No combinational path from instr to strobes outside DECODE/EXEC/BRANCH/MEMADR decoding.

Test Plan:
- rst held 2 cycles, then add x3,x1,x2 (0x002081B3), mem_ready=1 → FETCH,DECODE,EXECR(alu_cntrl=0),ALUWB(reg_write=1),FETCH; instret=1.
- sub (0x402081B3) then srai (0x4020D193) → EXECR alu_cntrl=1; EXECI alu_cntrl=9.
- lw (0x0000A183) with mem_ready low 3 cycles in MEMREAD → MEMREAD held 4 cycles, no reg_write until MEMWB; result_src=01.
- beq (0x00208463) with res_zero=1 → BRANCH alu_cntrl=7, pc_write=1; repeat with res_zero=0 → pc_write=0; bltu with res_lsb=1 → alu_cntrl=5, pc_write=1.
- Illegal opcode 0x0000007F → TRAP, illegal=1 held 10 cycles; then rst → FETCH, illegal=0, instret=0.
- rst asserted mid-MEMWRITE with mem_ready=0 → next cycle FETCH, mem_write=0, mem_req=1.
